// File: rtl/led_pattern_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sequencer_pkg
// Brief    : Shared types and constants for the LED pattern sequencer: mode
//            encoding, per-mode entry patterns and a ceil-log2 helper.
// Revision : 1.0 - initial release
// ============================================================================
package led_pattern_sequencer_pkg;

    // Mode encoding as seen on the MODE output pins
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    // LED value loaded when a mode is entered
    localparam logic [7:0] ENTRY_OFF    = 8'h00;
    localparam logic [7:0] ENTRY_BLINK  = 8'h00;
    localparam logic [7:0] ENTRY_CHASE  = 8'h01;
    localparam logic [7:0] ENTRY_BOUNCE = 8'h01;

    // Bounce travel direction
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Number of bits needed to hold values 0..value-1
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Entry pattern for a given mode
    function automatic logic [7:0] entry_pattern(input mode_t mode);
        logic [7:0] pattern;
        case (mode)
            MODE_OFF:    pattern = ENTRY_OFF;
            MODE_BLINK:  pattern = ENTRY_BLINK;
            MODE_CHASE:  pattern = ENTRY_CHASE;
            MODE_BOUNCE: pattern = ENTRY_BOUNCE;
            default:     pattern = ENTRY_OFF;
        endcase
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_sequencer_tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Brief    : Prescaler counting 0..DIV-1 and flagging the terminal count as
//            the base tick. Clear has priority over enable.
// Revision : 1.0 - initial release
// ============================================================================
module tick_divider
    import led_pattern_sequencer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic CLK_50,
    input  logic RST,
    input  logic ENABLE,
    input  logic CLEAR,
    output logic TICK
);

    localparam int                 c_cnt_w = clog2(DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_tick_cnt;

    // Free-running divide counter; holds while disabled, zeroes on clear
    always_ff @(posedge CLK_50) begin
        if (RST || CLEAR) begin
            r_tick_cnt <= '0;
        end else if (ENABLE) begin
            if (r_tick_cnt == c_last) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Tick only counts while enabled so a frozen terminal count cannot step
    assign TICK = ENABLE && (r_tick_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sequencer
// Brief    : Drives the 8 board LEDs with an animated pattern (OFF, BLINK,
//            CHASE, BOUNCE). A prescaler produces a base tick, a speed-
//            selectable step counter paces the animation and MODE_NEXT
//            cycles through the modes.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 8
) (
    input  logic       CLK_50,
    input  logic       RST,
    input  logic       MODE_NEXT,
    input  logic [1:0] SPEED,
    input  logic       PAUSE,
    output logic [7:0] LED,
    output logic [1:0] MODE,
    output logic       STEP
);

    localparam int c_div = CLK_HZ / TICK_HZ;

    mode_t      r_mode;
    logic [7:0] r_led;
    logic       r_dir;
    logic [2:0] r_step_cnt;
    logic       r_step;

    mode_t      w_mode_nxt;
    logic [7:0] w_led_nxt;
    logic       w_dir_nxt;
    logic [2:0] w_step_cnt_nxt;
    logic       w_step_nxt;
    logic [2:0] w_step_last;
    logic       w_tick;
    logic       w_div_en;

    // A mode change restarts the period, so the prescaler is cleared with it
    assign w_div_en = !PAUSE && !MODE_NEXT;

    tick_divider #(
        .DIV    (c_div)
    ) u_tick_divider (
        .CLK_50 (CLK_50),
        .RST    (RST),
        .ENABLE (w_div_en),
        .CLEAR  (MODE_NEXT),
        .TICK   (w_tick)
    );

    // Last step-counter value before a step fires: N-1 with N = 2^(3-SPEED)
    always_comb begin
        w_step_last = 3'd0;
        case (SPEED)
            2'd0:    w_step_last = 3'd7;
            2'd1:    w_step_last = 3'd3;
            2'd2:    w_step_last = 3'd1;
            default: w_step_last = 3'd0;
        endcase
    end

    // Next-state logic: mode change beats stepping; pause freezes everything
    always_comb begin
        w_mode_nxt     = r_mode;
        w_led_nxt      = r_led;
        w_dir_nxt      = r_dir;
        w_step_cnt_nxt = r_step_cnt;
        w_step_nxt     = 1'b0;

        if (MODE_NEXT) begin
            w_mode_nxt     = mode_t'(r_mode + 2'd1);
            w_led_nxt      = entry_pattern(w_mode_nxt);
            w_dir_nxt      = DIR_LEFT;
            w_step_cnt_nxt = 3'd0;
        end else if (w_tick) begin
            // >= so that lowering the period mid-count fires on the next tick
            if (r_step_cnt >= w_step_last) begin
                w_step_cnt_nxt = 3'd0;
                w_step_nxt     = 1'b1;
                case (r_mode)
                    MODE_OFF: begin
                        w_led_nxt = ENTRY_OFF;
                    end
                    MODE_BLINK: begin
                        w_led_nxt = ~r_led;
                    end
                    MODE_CHASE: begin
                        w_led_nxt = {r_led[6:0], r_led[7]};
                    end
                    MODE_BOUNCE: begin
                        // Turn around at either end without lighting it twice
                        if (r_dir == DIR_LEFT) begin
                            if (r_led[7]) begin
                                w_led_nxt = 8'h40;
                                w_dir_nxt = DIR_RIGHT;
                            end else begin
                                w_led_nxt = r_led << 1;
                            end
                        end else begin
                            if (r_led[0]) begin
                                w_led_nxt = 8'h02;
                                w_dir_nxt = DIR_LEFT;
                            end else begin
                                w_led_nxt = r_led >> 1;
                            end
                        end
                    end
                    default: begin
                        w_led_nxt = ENTRY_OFF;
                    end
                endcase
            end else begin
                w_step_cnt_nxt = r_step_cnt + 3'd1;
            end
        end
    end

    // State register for mode, pattern, direction and step pacing
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            r_mode     <= MODE_BLINK;
            r_led      <= 8'h00;
            r_dir      <= DIR_LEFT;
            r_step_cnt <= 3'd0;
            r_step     <= 1'b0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_led      <= w_led_nxt;
            r_dir      <= w_dir_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_step     <= w_step_nxt;
        end
    end

    assign LED  = r_led;
    assign MODE = r_mode;
    assign STEP = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Brief    : Directed self-checking bench for led_pattern_sequencer with
//            CLK_HZ=16, TICK_HZ=4 (four clocks per base tick).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sequencer;

    logic       CLK_50;
    logic       RST;
    logic       MODE_NEXT;
    logic [1:0] SPEED;
    logic       PAUSE;
    logic [7:0] LED;
    logic [1:0] MODE;
    logic       STEP;

    int n_tests;
    int n_fail;

    led_pattern_sequencer #(
        .CLK_HZ    (16),
        .TICK_HZ   (4)
    ) dut (
        .CLK_50    (CLK_50),
        .RST       (RST),
        .MODE_NEXT (MODE_NEXT),
        .SPEED     (SPEED),
        .PAUSE     (PAUSE),
        .LED       (LED),
        .MODE      (MODE),
        .STEP      (STEP)
    );

    initial CLK_50 = 1'b0;
    always #5 CLK_50 = ~CLK_50;

    // Advance one clock and settle just after the edge
    task automatic clk1();
        @(posedge CLK_50);
        #1;
    endtask

    // Apply a one-cycle MODE_NEXT pulse
    task automatic pulse_next();
        MODE_NEXT = 1'b1;
        clk1();
        MODE_NEXT = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; MODE_NEXT = 1'b0; PAUSE = 1'b0; SPEED = 2'd3;
        clk1();
        clk1();
        n_tests++; if (MODE !== 2'd1) begin n_fail++; $display("FAIL reset_mode: got %0d expected 1", MODE); end
        n_tests++; if (LED !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h expected 00", LED); end
        n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", STEP); end
        RST = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) begin
                clk1();
                n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL blink_gap s%0d c%0d: STEP got %b expected 0", s, i, STEP); end
            end
            clk1();
            n_tests++; if (STEP !== 1'b1) begin n_fail++; $display("FAIL blink_step s%0d: STEP got %b expected 1", s, STEP); end
            n_tests++; if (LED !== ((s == 0) ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL blink_led s%0d: got %h expected %h", s, LED, (s == 0) ? 8'hFF : 8'h00); end
        end
    endtask

    task automatic test_chase();
        logic [7:0] exp_seq [8];
        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        pulse_next();
        n_tests++; if (MODE !== 2'd2) begin n_fail++; $display("FAIL chase_mode: got %0d expected 2", MODE); end
        n_tests++; if (LED !== 8'h01) begin n_fail++; $display("FAIL chase_entry: got %h expected 01", LED); end
        n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL chase_entry_step: got %b expected 0", STEP); end
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 3; i++) begin
                clk1();
                n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL chase_gap s%0d: STEP got %b expected 0", s, STEP); end
            end
            clk1();
            n_tests++; if (STEP !== 1'b1 || LED !== exp_seq[s]) begin n_fail++; $display("FAIL chase_step s%0d: got LED=%h STEP=%b expected LED=%h STEP=1", s, LED, STEP, exp_seq[s]); end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp_seq [15];
        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        pulse_next();
        n_tests++; if (MODE !== 2'd3 || LED !== 8'h01) begin n_fail++; $display("FAIL bounce_entry: got MODE=%0d LED=%h expected MODE=3 LED=01", MODE, LED); end
        for (int s = 0; s < 15; s++) begin
            for (int i = 0; i < 3; i++) begin
                clk1();
                n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL bounce_gap s%0d: STEP got %b expected 0", s, STEP); end
            end
            clk1();
            n_tests++; if (STEP !== 1'b1 || LED !== exp_seq[s]) begin n_fail++; $display("FAIL bounce_step s%0d: got LED=%h STEP=%b expected LED=%h STEP=1", s, LED, STEP, exp_seq[s]); end
        end
    endtask

    task automatic test_speed_change();
        // Wraps BOUNCE -> OFF and restarts the period at the slowest speed
        SPEED = 2'd0;
        pulse_next();
        n_tests++; if (MODE !== 2'd0 || LED !== 8'h00) begin n_fail++; $display("FAIL off_entry: got MODE=%0d LED=%h expected MODE=0 LED=00", MODE, LED); end
        // Five ticks elapse in 20 clocks: step_cnt reaches 5 with no step
        for (int i = 0; i < 20; i++) begin
            clk1();
            n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL slow_gap c%0d: STEP got %b expected 0", i, STEP); end
        end
        SPEED = 2'd3;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) begin
                clk1();
                n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL fast_gap s%0d: STEP got %b expected 0", s, STEP); end
            end
            clk1();
            n_tests++; if (STEP !== 1'b1 || LED !== 8'h00) begin n_fail++; $display("FAIL fast_step s%0d: got LED=%h STEP=%b expected LED=00 STEP=1", s, LED, STEP); end
        end
    endtask

    task automatic test_pause();
        pulse_next();
        clk1();
        pulse_next();
        n_tests++; if (MODE !== 2'd2 || LED !== 8'h01) begin n_fail++; $display("FAIL pause_setup: got MODE=%0d LED=%h expected MODE=2 LED=01", MODE, LED); end
        for (int i = 0; i < 8; i++) clk1();
        n_tests++; if (LED !== 8'h04 || STEP !== 1'b1) begin n_fail++; $display("FAIL pause_pre: got LED=%h STEP=%b expected LED=04 STEP=1", LED, STEP); end
        clk1();
        clk1();
        PAUSE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk1();
            n_tests++; if (LED !== 8'h04 || STEP !== 1'b0) begin n_fail++; $display("FAIL pause_hold c%0d: got LED=%h STEP=%b expected LED=04 STEP=0", i, LED, STEP); end
        end
        PAUSE = 1'b0;
        clk1();
        n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL pause_resume_gap: STEP got %b expected 0", STEP); end
        clk1();
        n_tests++; if (STEP !== 1'b1 || LED !== 8'h08) begin n_fail++; $display("FAIL pause_resume_step: got LED=%h STEP=%b expected LED=08 STEP=1", LED, STEP); end
        PAUSE = 1'b1;
        pulse_next();
        n_tests++; if (MODE !== 2'd3 || LED !== 8'h01 || STEP !== 1'b0) begin n_fail++; $display("FAIL pause_next: got MODE=%0d LED=%h STEP=%b expected MODE=3 LED=01 STEP=0", MODE, LED, STEP); end
        for (int i = 0; i < 8; i++) begin
            clk1();
            n_tests++; if (LED !== 8'h01 || STEP !== 1'b0) begin n_fail++; $display("FAIL pause_next_hold c%0d: got LED=%h STEP=%b expected LED=01 STEP=0", i, LED, STEP); end
        end
        PAUSE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1();
            n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL pause_next_gap c%0d: STEP got %b expected 0", i, STEP); end
        end
        clk1();
        n_tests++; if (STEP !== 1'b1 || LED !== 8'h02) begin n_fail++; $display("FAIL pause_next_step: got LED=%h STEP=%b expected LED=02 STEP=1", LED, STEP); end
    endtask

    task automatic test_back_to_back();
        pulse_next();
        clk1();
        pulse_next();
        n_tests++; if (MODE !== 2'd1 || LED !== 8'h00) begin n_fail++; $display("FAIL b2b_setup: got MODE=%0d LED=%h expected MODE=1 LED=00", MODE, LED); end
        for (int i = 0; i < 4; i++) clk1();
        n_tests++; if (LED !== 8'hFF || STEP !== 1'b1) begin n_fail++; $display("FAIL b2b_pre: got LED=%h STEP=%b expected LED=FF STEP=1", LED, STEP); end
        for (int i = 0; i < 3; i++) clk1();
        // Step is due on this edge; the mode change must win
        pulse_next();
        n_tests++; if (MODE !== 2'd2 || LED !== 8'h01 || STEP !== 1'b0) begin n_fail++; $display("FAIL b2b_collide: got MODE=%0d LED=%h STEP=%b expected MODE=2 LED=01 STEP=0", MODE, LED, STEP); end
        for (int i = 0; i < 3; i++) begin
            clk1();
            n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL b2b_gap c%0d: STEP got %b expected 0", i, STEP); end
        end
        clk1();
        n_tests++; if (STEP !== 1'b1 || LED !== 8'h02) begin n_fail++; $display("FAIL b2b_step: got LED=%h STEP=%b expected LED=02 STEP=1", LED, STEP); end
    endtask

    task automatic test_reset_mid();
        pulse_next();
        for (int i = 0; i < 4; i++) clk1();
        n_tests++; if (MODE !== 2'd3 || LED !== 8'h02) begin n_fail++; $display("FAIL rst_mid_setup: got MODE=%0d LED=%h expected MODE=3 LED=02", MODE, LED); end
        clk1();
        clk1();
        RST = 1'b1; MODE_NEXT = 1'b1; PAUSE = 1'b1;
        clk1();
        n_tests++; if (MODE !== 2'd1 || LED !== 8'h00 || STEP !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got MODE=%0d LED=%h STEP=%b expected MODE=1 LED=00 STEP=0", MODE, LED, STEP); end
        RST = 1'b0; MODE_NEXT = 1'b0; PAUSE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1();
            n_tests++; if (STEP !== 1'b0) begin n_fail++; $display("FAIL rst_mid_gap c%0d: STEP got %b expected 0", i, STEP); end
        end
        clk1();
        n_tests++; if (STEP !== 1'b1 || LED !== 8'hFF) begin n_fail++; $display("FAIL rst_mid_step: got LED=%h STEP=%b expected LED=FF STEP=1", LED, STEP); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST = 1'b1; MODE_NEXT = 1'b0; PAUSE = 1'b0; SPEED = 2'd3;
        test_reset();
        test_chase();
        test_bounce();
        test_speed_change();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
